cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Reset i_reset is synchronous and active-high; clock is i_clock.
REQ-003 i_clock  in  1  clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 o_bus_request  out  1  instruction bus read request.
REQ-006 o_bus_address  out  32  byte address of requested word, bits [1:0] always 0.
REQ-007 i_bus_ready  in  1  one-cycle pulse: i_bus_rdata valid, transaction complete.
REQ-008 i_bus_rdata  in  32  fetched instruction word.
REQ-009 i_stall  in  1  downstream busy; no new transaction may start while high.
REQ-010 i_jump_valid  in  1  one-cycle pulse from execute: next PC resolved.
REQ-011 i_jump_pc  in  32  resolved next PC, sampled when i_jump_valid=1.
REQ-012 o_data  out  fetch_data_t  fields tag, pc, instruction driven; inst_rs1/rs2/rs3/inst_rd driven 0 (resolved downstream).

Function
REQ-013 Output protocol: consumer latches o_data whenever o_data.tag differs from its last latched tag; o_data SHALL change only together with a tag increment.
REQ-014 tag SHALL increment by 1 modulo 2^width per published instruction; wrap from all-ones to 0 is legal, only inequality matters.
REQ-015 Payload pc and instruction SHALL be stable on every cycle the tag is unchanged.
REQ-016 States: FETCH, WAIT_JUMP; reset state FETCH.
REQ-017 FETCH: o_bus_request=1 with o_bus_address=pc when i_stall=0 or a request is already outstanding.
REQ-018 Once asserted, o_bus_request and o_bus_address SHALL hold until the cycle i_bus_ready=1, regardless of i_stall.
REQ-019 On i_bus_ready in FETCH: next cycle o_data.tag=tag+1, o_data.pc=pc, o_data.instruction=i_bus_rdata; pc<=pc+4 (32-bit wrap, FFFF_FFFC->0000_0000).
REQ-020 o_bus_request SHALL be 0 in the cycle after i_bus_ready (one idle cycle between transactions).
REQ-021 Control transfer: if i_bus_rdata[6:0] is 1101111 (JAL), 1100111 (JALR) or 1100011 (BRANCH), publish it, then enter WAIT_JUMP.
REQ-022 WAIT_JUMP: o_bus_request=0; on i_jump_valid, pc<={i_jump_pc[31:2],2'b00} and return to FETCH.
REQ-023 i_jump_valid in FETCH SHALL be ignored (no pc change, no state change).
REQ-024 i_bus_ready without an outstanding request SHALL be ignored.
REQ-025 Latency: i_bus_ready at cycle N -> new o_data visible at N+1; i_jump_valid at cycle N -> request at N+1 if i_stall=0.

Reset
REQ-026 During reset: o_bus_request=0, o_bus_address=RESET_VECTOR, o_data=0 (tag 0), pc=RESET_VECTOR, state FETCH.
REQ-027 Reset mid-transaction SHALL abandon the request; a pending i_bus_ready in the reset cycle SHALL be discarded.
REQ-028 First request SHALL assert in the first cycle after reset deasserts, if i_stall=0.

Verification
REQ-029 Reset release, i_stall=0, ready after 2 cycles with rdata 0000_0013 -> request @0x0, then o_data tag=1 pc=0 instr=0000_0013, next request @0x4.
REQ-030 i_stall=1 for 5 cycles from reset -> request stays 0; i_stall falls -> request @RESET_VECTOR next cycle.
REQ-031 Request outstanding, i_stall rises before ready -> request/address hold until ready, then no new request until i_stall=0.
REQ-032 Fetch 0000_006F (JAL) @0x8 -> published, no further requests; i_jump_valid with pc 0x103 -> next request @0x100, tag increments by exactly 1 per instruction.
REQ-033 Set pc to FFFF_FFFC via jump, fetch non-branch -> next request @0x0000_0000.
REQ-034 Reset asserted in cycle of i_bus_ready -> o_data=0, no tag change, first request @RESET_VECTOR after release.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types for the instruction fetch stage.
// fetch_data_t is the payload published to decode, qualified by its tag.
package cpu_fetch_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 8;
   localparam int unsigned REG_W = 5;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instruction;
      logic [REG_W-1:0] inst_rs1;
      logic [REG_W-1:0] inst_rs2;
      logic [REG_W-1:0] inst_rs3;
      logic [REG_W-1:0] inst_rd;
   } fetch_data_t;

endpackage

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: issues one bus read at a time and publishes each word with a new tag.
// After a control-transfer instruction it idles until execute resolves the next PC.
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic              i_clock,
   input  logic              i_reset,
   output logic              o_bus_request,
   output logic [XLEN-1:0]   o_bus_address,
   input  logic              i_bus_ready,
   input  logic [XLEN-1:0]   i_bus_rdata,
   input  logic              i_stall,
   input  logic              i_jump_valid,
   input  logic [XLEN-1:0]   i_jump_pc,
   output fetch_data_t       o_data
);

   localparam logic [XLEN-1:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [0:0] {
      FETCH,
      WAIT_JUMP
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] jump_target_c;
   logic [6:0]      opcode_c;
   logic            is_ctrl_c;
   logic            jump_pc_unused;

   assign opcode_c       = i_bus_rdata[6:0];
   assign is_ctrl_c      = (opcode_c == OP_JAL) || (opcode_c == OP_JALR) || (opcode_c == OP_BRANCH);
   assign jump_target_c  = {i_jump_pc[31:2], 2'b00};
   assign jump_pc_unused = ^i_jump_pc[1:0];

   // Fetch FSM; request, address and published payload are all registered here.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         o_bus_request <= 1'b0;
         o_bus_address <= RESET_PC;
         o_data        <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (o_bus_request) begin
                  // Outstanding request holds regardless of stall until the bus answers.
                  if (i_bus_ready) begin
                     o_bus_request      <= 1'b0;
                     o_data.tag         <= o_data.tag + TAG_W'(1);
                     o_data.pc          <= pc;
                     o_data.instruction <= i_bus_rdata;
                     pc                 <= pc + XLEN'(4);
                     if (is_ctrl_c) begin
                        state <= WAIT_JUMP;
                     end
                  end
               end else if (!i_stall) begin
                  o_bus_request <= 1'b1;
                  o_bus_address <= pc;
               end
            end
            WAIT_JUMP: begin
               if (i_jump_valid) begin
                  pc    <= jump_target_c;
                  state <= FETCH;
                  if (!i_stall) begin
                     o_bus_request <= 1'b1;
                     o_bus_address <= jump_target_c;
                  end
               end
            end
            default: begin
               state         <= FETCH;
               o_bus_request <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: a scoreboard of expected published words is filled
// when the bus answers and drained whenever the tag moves.
module tb_cpu_fetch;
   import cpu_fetch_pkg::*;

   logic              i_clock;
   logic              i_reset;
   logic              o_bus_request;
   logic [XLEN-1:0]   o_bus_address;
   logic              i_bus_ready;
   logic [XLEN-1:0]   i_bus_rdata;
   logic              i_stall;
   logic              i_jump_valid;
   logic [XLEN-1:0]   i_jump_pc;
   fetch_data_t       o_data;

   int                tests = 0;
   int                fails = 0;
   fetch_data_t       sb[$];
   fetch_data_t       last_pub;
   logic [TAG_W-1:0]  model_tag;

   cpu_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .o_bus_request (o_bus_request),
      .o_bus_address (o_bus_address),
      .i_bus_ready   (i_bus_ready),
      .i_bus_rdata   (i_bus_rdata),
      .i_stall       (i_stall),
      .i_jump_valid  (i_jump_valid),
      .i_jump_pc     (i_jump_pc),
      .o_data        (o_data)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Advance one cycle, then compare any publication against the scoreboard.
   task automatic step();
      fetch_data_t e;
      @(posedge i_clock);
      #1;
      if (i_reset) begin
         sb.delete();
         last_pub  = '0;
         model_tag = '0;
      end else if (o_data.tag !== last_pub.tag) begin
         if (sb.size() == 0) begin
            check("unexpected_publish", 128'(o_data.tag), 128'(last_pub.tag));
         end else begin
            e = sb.pop_front();
            check("published_word", 128'(o_data), 128'(e));
            last_pub = e;
         end
      end else begin
         check("payload_stable", 128'(o_data), 128'(last_pub));
      end
   endtask

   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                        input int hold, input logic stall_during);
      fetch_data_t e;
      int n;
      n = 0;
      while (!o_bus_request && n < 20) begin
         step();
         n++;
      end
      check("req_seen", 128'(o_bus_request), 128'(1'b1));
      check("req_addr", 128'(o_bus_address), 128'(exp_addr));
      i_stall = stall_during;
      for (int i = 0; i < hold; i++) begin
         step();
         check("req_hold", 128'(o_bus_request), 128'(1'b1));
         check("addr_hold", 128'(o_bus_address), 128'(exp_addr));
      end
      i_bus_ready = 1'b1;
      i_bus_rdata = rdata;
      model_tag   = model_tag + 8'd1;
      e             = '0;
      e.tag         = model_tag;
      e.pc          = exp_addr;
      e.instruction = rdata;
      sb.push_back(e);
      step();
      i_bus_ready = 1'b0;
      i_bus_rdata = 32'hDEAD_BEEF;
      check("pub_latency", 128'(sb.size()), 128'(0));
      check("idle_after_ready", 128'(o_bus_request), 128'(1'b0));
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] r;
      int n;
      i_reset      = 1'b1;
      i_bus_ready  = 1'b0;
      i_bus_rdata  = 32'h0;
      i_stall      = 1'b0;
      i_jump_valid = 1'b0;
      i_jump_pc    = 32'h0;
      last_pub     = '0;
      model_tag    = '0;

      // Reset values
      for (int i = 0; i < 3; i++) step();
      check("rst_req", 128'(o_bus_request), 128'(1'b0));
      check("rst_addr", 128'(o_bus_address), 128'(32'h0));
      check("rst_data", 128'(o_data), 128'(0));

      // Stall held from reset: no request until it falls
      i_stall = 1'b1;
      i_reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_no_req", 128'(o_bus_request), 128'(1'b0));
      end
      i_stall = 1'b0;
      step();
      check("unstall_req", 128'(o_bus_request), 128'(1'b1));
      check("unstall_addr", 128'(o_bus_address), 128'(32'h0));

      // Sequential fetches
      fetch(32'h0, 32'h0000_0013, 2, 1'b0);
      step();
      check("next_req", 128'(o_bus_request), 128'(1'b1));
      check("next_addr", 128'(o_bus_address), 128'(32'h4));
      fetch(32'h4, 32'h0010_0093, 0, 1'b0);

      // JAL: published then idle until the jump resolves
      fetch(32'h8, 32'h0000_006F, 1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         i_bus_ready = (i == 1);
         step();
         check("wait_jump_no_req", 128'(o_bus_request), 128'(1'b0));
      end
      i_bus_ready  = 1'b0;
      i_jump_valid = 1'b1;
      i_jump_pc    = 32'h0000_0103;
      step();
      i_jump_valid = 1'b0;
      check("jump_req", 128'(o_bus_request), 128'(1'b1));
      check("jump_addr", 128'(o_bus_address), 128'(32'h100));

      // Stall rises with a request outstanding; stray ready/jump while idle are ignored
      fetch(32'h100, 32'h0000_0013, 3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         i_bus_ready  = (i == 1);
         i_jump_valid = (i == 2);
         i_jump_pc    = 32'h0000_0700;
         step();
         check("stalled_idle", 128'(o_bus_request), 128'(1'b0));
      end
      i_bus_ready  = 1'b0;
      i_jump_valid = 1'b0;
      i_stall      = 1'b0;
      step();
      check("resume_req", 128'(o_bus_request), 128'(1'b1));
      check("resume_addr", 128'(o_bus_address), 128'(32'h104));

      // BRANCH, jump to the top of memory while stalled, then PC wrap
      fetch(32'h104, 32'h0000_0063, 0, 1'b0);
      i_stall      = 1'b1;
      i_jump_valid = 1'b1;
      i_jump_pc    = 32'hFFFF_FFFE;
      step();
      i_jump_valid = 1'b0;
      check("jump_stalled", 128'(o_bus_request), 128'(1'b0));
      step();
      check("jump_stalled2", 128'(o_bus_request), 128'(1'b0));
      i_stall = 1'b0;
      step();
      check("top_req", 128'(o_bus_request), 128'(1'b1));
      check("top_addr", 128'(o_bus_address), 128'(32'hFFFF_FFFC));
      fetch(32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b0);
      step();
      check("wrap_addr", 128'(o_bus_address), 128'(32'h0));

      // JALR then a long run crossing the tag wrap
      fetch(32'h0, 32'h0000_8067, 0, 1'b0);
      i_jump_valid = 1'b1;
      i_jump_pc    = 32'h0000_0040;
      step();
      i_jump_valid = 1'b0;
      addr = 32'h40;
      for (int i = 0; i < 260; i++) begin
         r      = $urandom();
         r[6:0] = 7'h13;
         fetch(addr, r, int'($urandom_range(0, 2)), 1'b0);
         addr = addr + 32'd4;
      end

      // Reset in the same cycle as bus ready: response discarded
      n = 0;
      while (!o_bus_request && n < 20) begin
         step();
         n++;
      end
      check("pre_rst_addr", 128'(o_bus_address), 128'(addr));
      i_bus_ready = 1'b1;
      i_bus_rdata = 32'h0000_0013;
      i_reset     = 1'b1;
      step();
      i_bus_ready = 1'b0;
      check("rst_ready_data", 128'(o_data), 128'(0));
      check("rst_ready_req", 128'(o_bus_request), 128'(1'b0));
      check("rst_ready_addr", 128'(o_bus_address), 128'(32'h0));
      i_reset = 1'b0;
      step();
      check("post_rst_req", 128'(o_bus_request), 128'(1'b1));
      check("post_rst_addr", 128'(o_bus_address), 128'(32'h0));
      fetch(32'h0, 32'h0000_0013, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
